// File: rtl/conv33_window.sv
// conv33_window: 3x3 sliding-window generator for a raster-order pixel stream.
// Two line buffers keep the previous two rows; each accepted pixel at row>=2,
// col>=2 produces one registered 3x3 window with a single-cycle valid strobe.
// Pixel data is passed through bit-exact, so signedness is preserved.
module conv33_window #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_valid,
    input  logic                  pix_sof,
    input  logic [DATA_WIDTH-1:0] pix_data,
    output logic [DATA_WIDTH-1:0] win_0_0,
    output logic [DATA_WIDTH-1:0] win_0_1,
    output logic [DATA_WIDTH-1:0] win_0_2,
    output logic [DATA_WIDTH-1:0] win_1_0,
    output logic [DATA_WIDTH-1:0] win_1_1,
    output logic [DATA_WIDTH-1:0] win_1_2,
    output logic [DATA_WIDTH-1:0] win_2_0,
    output logic [DATA_WIDTH-1:0] win_2_1,
    output logic [DATA_WIDTH-1:0] win_2_2,
    output logic                  win_valid,
    output logic                  frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0]         col_q, col_d, col_eff;
    logic [RW-1:0]         row_q, row_d, row_eff;
    logic [DATA_WIDTH-1:0] lb_a_q [IMG_W];
    logic [DATA_WIDTH-1:0] lb_a_d [IMG_W];
    logic [DATA_WIDTH-1:0] lb_b_q [IMG_W];
    logic [DATA_WIDTH-1:0] lb_b_d [IMG_W];
    logic [DATA_WIDTH-1:0] win_q  [3][3];
    logic [DATA_WIDTH-1:0] win_d  [3][3];
    logic                  win_valid_q, win_valid_d;
    logic                  frame_done_q, frame_done_d;

    // A start-of-frame pixel is treated as (0,0) no matter where the counters were
    always_comb begin
        row_eff = pix_sof ? '0 : row_q;
        col_eff = pix_sof ? '0 : col_q;
    end

    // Next-state: shift the window, update line buffers at the current column, advance counters
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        lb_a_d       = lb_a_q;
        lb_b_d       = lb_b_q;
        win_d        = win_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        if (pix_valid) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb_b_q[col_eff];
            win_d[1][2] = lb_a_q[col_eff];
            win_d[2][2] = pix_data;

            lb_b_d[col_eff] = lb_a_q[col_eff];
            lb_a_d[col_eff] = pix_data;

            win_valid_d  = (row_eff >= ROW_TWO) && (col_eff >= COL_TWO);
            frame_done_d = (row_eff == ROW_LAST) && (col_eff == COL_LAST);

            if (col_eff == COL_LAST) begin
                col_d = '0;
                row_d = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
            end else begin
                col_d = col_eff + 1'b1;
                row_d = row_eff;
            end
        end
    end

    // State registers; reset clears counters, line buffers and the window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < IMG_W; i++) begin
                lb_a_q[i] <= '0;
                lb_b_q[i] <= '0;
            end
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            lb_a_q       <= lb_a_d;
            lb_b_q       <= lb_b_d;
            win_q        <= win_d;
        end
    end

    assign win_0_0    = win_q[0][0];
    assign win_0_1    = win_q[0][1];
    assign win_0_2    = win_q[0][2];
    assign win_1_0    = win_q[1][0];
    assign win_1_1    = win_q[1][1];
    assign win_1_2    = win_q[1][2];
    assign win_2_0    = win_q[2][0];
    assign win_2_1    = win_q[2][1];
    assign win_2_2    = win_q[2][2];
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv33_window.sv
// tb_conv33_window: scoreboard bench for conv33_window on a 5x4 image.
// The driver pushes the expected window for each pixel at row>=2, col>=2;
// a monitor pops and compares whenever win_valid is seen.
module tb_conv33_window;

    localparam int DW = 8;
    localparam int W  = 5;
    localparam int H  = 4;

    typedef struct {
        logic [9*DW-1:0] win;
        logic            fd;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pix_valid = 1'b0;
    logic          pix_sof = 1'b0;
    logic [DW-1:0] pix_data = '0;
    logic [DW-1:0] win_0_0, win_0_1, win_0_2;
    logic [DW-1:0] win_1_0, win_1_1, win_1_2;
    logic [DW-1:0] win_2_0, win_2_1, win_2_2;
    logic          win_valid, frame_done;

    exp_t            exp_q[$];
    logic [9*DW-1:0] win_log[$];
    int              fd_count = 0;
    int              n_checks = 0;
    int              n_errors = 0;
    int              img [H][W];

    conv33_window #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst),
        .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
        .win_0_0(win_0_0), .win_0_1(win_0_1), .win_0_2(win_0_2),
        .win_1_0(win_1_0), .win_1_1(win_1_1), .win_1_2(win_1_2),
        .win_2_0(win_2_0), .win_2_1(win_2_1), .win_2_2(win_2_2),
        .win_valid(win_valid), .frame_done(frame_done)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    function automatic logic [9*DW-1:0] actual_win();
        return {win_0_0, win_0_1, win_0_2, win_1_0, win_1_1, win_1_2,
                win_2_0, win_2_1, win_2_2};
    endfunction

    function automatic logic [9*DW-1:0] pack9(int a, int b, int c, int d, int e,
                                              int f, int g, int h, int i);
        return {a[DW-1:0], b[DW-1:0], c[DW-1:0], d[DW-1:0], e[DW-1:0],
                f[DW-1:0], g[DW-1:0], h[DW-1:0], i[DW-1:0]};
    endfunction

    function automatic void check_output(string name, logic [9*DW-1:0] act,
                                         logic [9*DW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    // Monitor: compare every presented window with the oldest expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (win_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("[TB] FAIL unexpected_window: got %h with no window expected",
                             actual_win());
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_output("window", actual_win(), e.win);
                    check_output("frame_done", {71'd0, frame_done}, {71'd0, e.fd});
                    win_log.push_back(actual_win());
                    if (frame_done) fd_count++;
                end
            end else if (frame_done) begin
                n_checks++;
                n_errors++;
                $display("[TB] FAIL stray_frame_done: got 1 without win_valid, expected 0");
            end
        end
    end

    task automatic set_img(input int base);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = base + 5 * r + c;
    endtask

    // Drive one pixel for one cycle and record the window it should produce
    task automatic apply_stimulus(input int r, input int c, input logic sof);
        int v;
        v = img[r][c];
        pix_valid = 1'b1;
        pix_sof   = sof;
        pix_data  = v[DW-1:0];
        if (r >= 2 && c >= 2) begin
            exp_t e;
            e.win = pack9(img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                          img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                          img[r][c-2],   img[r][c-1],   img[r][c]);
            e.fd  = (r == H - 1) && (c == W - 1);
            exp_q.push_back(e);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    // Send the first npix pixels of img, sof on the first, optional random gaps
    task automatic send_frame(input int npix, input bit gaps);
        for (int p = 0; p < npix; p++) begin
            apply_stimulus(p / W, p % W, p == 0);
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    // Bounded wait for the scoreboard to empty
    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_output("queue_empty", 72'(exp_q.size()), 72'd0);
    endtask

    task automatic start_test(input string name);
        $display("[TB] test: %s", name);
        win_log.delete();
        fd_count = 0;
    endtask

    task automatic check_log_size(input int n);
        check_output("window_count", 72'(win_log.size()), 72'(n));
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_output("reset_window", actual_win(), '0);
        check_output("reset_flags", {70'd0, win_valid, frame_done}, 72'd0);
        rst = 1'b0;
        @(negedge clk);

        start_test("basic frame");
        set_img(0);
        send_frame(W * H, 1'b0);
        drain();
        check_log_size(6);
        if (win_log.size() == 6) begin
            check_output("basic_first", win_log[0], pack9(0, 1, 2, 5, 6, 7, 10, 11, 12));
            check_output("basic_last", win_log[5], pack9(7, 8, 9, 12, 13, 14, 17, 18, 19));
        end
        check_output("basic_fd_count", 72'(fd_count), 72'd1);

        start_test("gaps");
        set_img(0);
        send_frame(W * H, 1'b1);
        drain();
        check_log_size(6);
        if (win_log.size() == 6) begin
            check_output("gaps_first", win_log[0], pack9(0, 1, 2, 5, 6, 7, 10, 11, 12));
            check_output("gaps_last", win_log[5], pack9(7, 8, 9, 12, 13, 14, 17, 18, 19));
        end
        check_output("gaps_fd_count", 72'(fd_count), 72'd1);

        start_test("back-to-back");
        set_img(0);
        send_frame(W * H, 1'b0);
        set_img(100);
        send_frame(W * H, 1'b0);
        drain();
        check_log_size(12);
        if (win_log.size() == 12)
            check_output("b2b_frame2_first", win_log[6],
                         pack9(100, 101, 102, 105, 106, 107, 110, 111, 112));
        check_output("b2b_fd_count", 72'(fd_count), 72'd2);

        start_test("mid-frame resync");
        set_img(40);
        send_frame(8, 1'b0);
        set_img(20);
        send_frame(W * H, 1'b0);
        drain();
        check_log_size(6);
        if (win_log.size() == 6)
            check_output("resync_first", win_log[0],
                         pack9(20, 21, 22, 25, 26, 27, 30, 31, 32));
        check_output("resync_fd_count", 72'(fd_count), 72'd1);

        start_test("reset mid-frame");
        set_img(50);
        send_frame(12, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_output("async_reset_window", actual_win(), '0);
        check_output("async_reset_flags", {70'd0, win_valid, frame_done}, 72'd0);
        @(negedge clk);
        rst = 1'b0;
        set_img(60);
        send_frame(W * H, 1'b0);
        drain();
        check_log_size(6);
        if (win_log.size() == 6)
            check_output("post_reset_first", win_log[0],
                         pack9(60, 61, 62, 65, 66, 67, 70, 71, 72));
        check_output("post_reset_fd_count", 72'(fd_count), 72'd1);

        start_test("signed pass-through");
        set_img(0);
        img[2][2] = -128;
        img[2][3] = 127;
        send_frame(W * H, 1'b0);
        drain();
        check_log_size(6);
        if (win_log.size() == 6) begin
            check_output("signed_w22", 72'(win_log[0][7:0]), 72'h80);
            check_output("signed_w21_w22", 72'(win_log[1][15:0]), 72'h807F);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the bench always terminates
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation still running at time limit, expected completion");
        n_errors++;
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/conv33_window.md
Name: conv33_window

Overview:
- Upstream feeder for the 3x3 convolution calculator.
- Accepts a raster-order pixel stream, one pixel per valid cycle, and buffers the two previous image rows in line buffers.
- Each cycle it presents a complete 3x3 neighbourhood on nine registered outputs with a one-cycle valid strobe, which drives the calculator's data_r_c inputs and conv33_en.
- Convolution mode is "valid" (no padding): one window per pixel at row>=2, col>=2.

Parameters:
- DATA_WIDTH, 8, pixel width in bits (signed, passed through unmodified).
- IMG_W, 28, image width in pixels; must be >=3.
- IMG_H, 28, image height in rows; must be >=3.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- pix_valid  in  1  pixel present this cycle. No backpressure: every valid pixel is accepted.
- pix_sof  in  1  start-of-frame; qualified by pix_valid; marks the pixel as (row 0, col 0).
- pix_data  in  DATA_WIDTH  signed pixel.
- win_0_0..win_2_2  out  DATA_WIDTH each (9 ports)  window. Row 0 is oldest (top), col 2 is newest (right); win_2_2 is the most recently accepted pixel.
- win_valid  out  1  window valid, one-cycle pulse per emitted window.
- frame_done  out  1  one-cycle pulse coincident with the last window of a frame.

Behaviour:
- Reset:
  - All win_* outputs are 0; win_valid and frame_done are 0.
  - Row and column counters are 0.
  - Both line buffers are cleared to 0.
  - Reset asserted mid-frame discards the partial frame; the next frame must begin with pix_sof.
- Storage:
  - Two IMG_W-deep line buffers. lb_a holds row r-1 and lb_b holds row r-2, both indexed by column.
  - Implementation choice is shift-register or RAM with a column pointer. Either way, the read-before-write value at column c is used.
- On an accepted pixel at (r,c):
  - Window columns shift left: win_x_0 <= win_x_1 and win_x_1 <= win_x_2.
  - New right column: win_0_2 <= lb_b[c], win_1_2 <= lb_a[c], win_2_2 <= pix_data.
  - Line buffers update: lb_b[c] <= lb_a[c] and lb_a[c] <= pix_data.
- Latency: window outputs update, and win_valid asserts, on the clock edge following acceptance (1 cycle).
- win_valid:
  - Equals 1 in the cycle after a pixel accepted with r>=2 and c>=2; otherwise 0.
  - Exactly (IMG_W-2)*(IMG_H-2) pulses per frame.
- Gaps: when pix_valid=0, counters, line buffers and window registers hold, and win_valid=0. Gaps of any length are allowed, including mid-row.
- Counters:
  - col increments per accepted pixel and wraps IMG_W-1 -> 0, incrementing row.
  - row wraps IMG_H-1 -> 0.
  - After the last pixel (IMG_H-1, IMG_W-1), frame_done pulses together with that window's win_valid. The counters then read (0,0), so back-to-back frames need no idle cycle.
- pix_sof:
  - With pix_valid=1, pix_data is treated as (0,0) regardless of counter state, and counters then advance from (0,0).
  - SOF mid-frame aborts the partial frame: no frame_done, and no further windows until row 2 of the new frame.
  - Stale buffer contents never appear under win_valid=1.
  - pix_sof with pix_valid=0 is ignored.
- Row edges:
  - Windows never span rows under win_valid=1; the first two shifts of each row flush the prior row's columns.
  - Window contents while win_valid=0 are don't-care for checking.
- Arithmetic: none; data is passed bit-exact, sign preserved.

Test Plan:
- Bench configuration: IMG_W=5, IMG_H=4.
- Basic frame: one frame, pixel value = 5r+c, continuous valid, sof on pixel 0.
  - First win_valid one cycle after pixel 12 is accepted, with window 0,1,2 / 5,6,7 / 10,11,12.
  - Six windows total; the last is 7,8,9 / 12,13,14 / 17,18,19, and frame_done pulses with it.
- Gaps: same frame with pix_valid toggling 1-0-0-1 pseudo-randomly -> identical six windows in identical order, win_valid never asserted during gap cycles, same frame_done.
- Back-to-back frames: two consecutive frames with no idle cycle, second frame value = 100+5r+c -> 12 windows total; first window of frame 2 is 100,101,102 / 105,106,107 / 110,111,112; two frame_done pulses.
- Mid-frame resync: sof asserted on the 9th pixel of a frame -> no frame_done for the aborted frame; the following full frame yields exactly six correct windows.
- Reset mid-frame: rst during row 2 -> all outputs 0 immediately (asynchronous); a new frame after release yields correct windows with no stale data.
- Signed pass-through: pixels -128 and 127 at (2,2) and (2,3) -> win_2_2 reads -128, then win_2_1=-128 and win_2_2=127 on the next window.
